// File: rtl/tb_halt_monitor_if.sv
// Signal bundle between the CPU bench top and its end-of-simulation monitor.
// The bench side (master) drives the per-channel RVFI taps and the limits; the monitor (slave) reports status.
interface tb_halt_monitor_if #(
  parameter int NUM_CH = 2,
  parameter int ERR_W  = 16,
  parameter int CNT_W  = 32
);
  localparam int CH_W = $clog2(NUM_CH) + 1;

  logic [NUM_CH-1:0]       halt_i;
  logic [NUM_CH-1:0]       commit_i;
  logic [NUM_CH*ERR_W-1:0] errcode_i;
  logic [CNT_W-1:0]        timeout_i;
  logic [CNT_W-1:0]        stall_limit_i;

  // finish_o is a bare one-cycle strobe with no ready: the bench must sample it every
  // cycle, and done_o stays high afterwards so a late observer still sees termination.
  logic                    finish_o;
  logic                    done_o;
  logic [2:0]              cause_o;
  logic [CH_W-1:0]         cause_ch_o;
  logic [ERR_W-1:0]        err_code_o;
  logic [CNT_W-1:0]        cycle_o;
  logic [1:0]              state_o;

  modport master (
    output halt_i, commit_i, errcode_i, timeout_i, stall_limit_i,
    input  finish_o, done_o, cause_o, cause_ch_o, err_code_o, cycle_o, state_o
  );

  modport slave (
    input  halt_i, commit_i, errcode_i, timeout_i, stall_limit_i,
    output finish_o, done_o, cause_o, cause_ch_o, err_code_o, cycle_o, state_o
  );
endinterface

// File: rtl/tb_halt_monitor.sv
// End-of-simulation controller: watches N commit channels for halt, error, global timeout
// and commit stall, latches the first cause and raises a one-cycle finish request.
module tb_halt_monitor #(
  parameter int NUM_CH       = 2,
  parameter int ERR_W        = 16,
  parameter int CNT_W        = 32,
  parameter int DRAIN_CYCLES = 5
) (
  input  logic             clk,
  input  logic             rst,
  tb_halt_monitor_if.slave mon
);
  localparam int CH_W = $clog2(NUM_CH) + 1;
  localparam int DR_W = $clog2(DRAIN_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [DR_W-1:0]  DR_ONE  = {{(DR_W-1){1'b0}}, 1'b1};
  localparam logic [DR_W-1:0]  DR_LAST = DR_W'(DRAIN_CYCLES - 1);

  localparam logic [2:0] CAUSE_HALT    = 3'd1;
  localparam logic [2:0] CAUSE_ERROR   = 3'd2;
  localparam logic [2:0] CAUSE_TIMEOUT = 3'd3;
  localparam logic [2:0] CAUSE_STALL   = 3'd4;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                         state_q;
  logic [NUM_CH-1:0]              halted_q;
  logic [NUM_CH-1:0][CNT_W-1:0]   stall_q;
  logic [DR_W-1:0]                drain_q;
  logic [CNT_W-1:0]               cycle_q;
  logic                           finish_q;
  logic                           done_q;
  logic [2:0]                     cause_q;
  logic [CH_W-1:0]                cause_ch_q;
  logic [ERR_W-1:0]               err_q;

  logic [NUM_CH-1:0]              halted_d;
  logic [NUM_CH-1:0][CNT_W-1:0]   stall_d;
  logic [CNT_W-1:0]               cycle_d;
  logic [NUM_CH-1:0]              stall_fire;
  logic                           all_halted;
  logic                           timeout_hit;
  logic                           err_hit;
  logic [CH_W-1:0]                err_ch;
  logic [ERR_W-1:0]               err_val;
  logic                           stall_hit;
  logic [CH_W-1:0]                stall_ch;

  always_comb begin
    halted_d    = halted_q | mon.halt_i;
    all_halted  = &halted_d;
    cycle_d     = (&cycle_q) ? cycle_q : cycle_q + CNT_ONE;
    timeout_hit = (mon.timeout_i != '0) && ((cycle_q + CNT_ONE) == mon.timeout_i);
    err_hit     = 1'b0;
    err_ch      = '0;
    err_val     = '0;
    stall_hit   = 1'b0;
    stall_ch    = '0;
    stall_fire  = '0;
    stall_d     = stall_q;
    // Walk from the top channel down so the lowest-numbered hit is the one left standing.
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (mon.errcode_i[k*ERR_W +: ERR_W] != '0) begin
        err_hit = 1'b1;
        err_ch  = CH_W'(k);
        err_val = mon.errcode_i[k*ERR_W +: ERR_W];
      end
      stall_fire[k] = (mon.stall_limit_i != '0) && !halted_d[k] && !mon.commit_i[k] &&
                      ((stall_q[k] + CNT_ONE) == mon.stall_limit_i);
      if (stall_fire[k]) begin
        stall_hit = 1'b1;
        stall_ch  = CH_W'(k);
      end
      if (!halted_d[k]) begin
        if (mon.commit_i[k])     stall_d[k] = '0;
        else if (!(&stall_q[k])) stall_d[k] = stall_q[k] + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_RUN;
      halted_q   <= '0;
      stall_q    <= '0;
      drain_q    <= '0;
      cycle_q    <= '0;
      finish_q   <= 1'b0;
      done_q     <= 1'b0;
      cause_q    <= '0;
      cause_ch_q <= '0;
      err_q      <= '0;
    end else begin
      finish_q <= 1'b0;
      case (state_q)
        S_RUN: begin
          halted_q <= halted_d;
          stall_q  <= stall_d;
          cycle_q  <= cycle_d;
          if (err_hit) begin
            state_q    <= S_DRAIN;
            drain_q    <= '0;
            cause_q    <= CAUSE_ERROR;
            cause_ch_q <= err_ch;
            err_q      <= err_val;
          end else if (all_halted) begin
            state_q  <= S_DONE;
            finish_q <= 1'b1;
            done_q   <= 1'b1;
            cause_q  <= CAUSE_HALT;
          end else if (timeout_hit) begin
            state_q  <= S_DONE;
            finish_q <= 1'b1;
            done_q   <= 1'b1;
            cause_q  <= CAUSE_TIMEOUT;
          end else if (stall_hit) begin
            state_q    <= S_DONE;
            finish_q   <= 1'b1;
            done_q     <= 1'b1;
            cause_q    <= CAUSE_STALL;
            cause_ch_q <= stall_ch;
          end
        end
        // Give the core time to flush its error report before the bench stops.
        S_DRAIN: begin
          if (drain_q == DR_LAST) begin
            state_q  <= S_DONE;
            finish_q <= 1'b1;
            done_q   <= 1'b1;
          end else begin
            drain_q <= drain_q + DR_ONE;
          end
        end
        S_DONE:  ;
        default: state_q <= S_RUN;
      endcase
    end
  end

  assign mon.finish_o   = finish_q;
  assign mon.done_o     = done_q;
  assign mon.cause_o    = cause_q;
  assign mon.cause_ch_o = cause_ch_q;
  assign mon.err_code_o = err_q;
  assign mon.cycle_o    = cycle_q;
  assign mon.state_o    = state_q;
endmodule

// File: tb/tb_tb_halt_monitor.sv
// Bench for tb_halt_monitor: directed scenarios plus randomized traces checked against
// a trace-scanning reference model (first cycle at which each termination rule holds).
module tb_tb_halt_monitor;
  localparam int NUM_CH = 2;
  localparam int ERR_W  = 16;
  localparam int CNT_W  = 32;
  localparam int DRAIN  = 5;
  localparam int MAXT   = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tb_halt_monitor_if #(.NUM_CH(NUM_CH), .ERR_W(ERR_W), .CNT_W(CNT_W)) bus ();

  tb_halt_monitor #(.NUM_CH(NUM_CH), .ERR_W(ERR_W), .CNT_W(CNT_W), .DRAIN_CYCLES(DRAIN)) dut (
    .clk (clk),
    .rst (rst),
    .mon (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0]        halt_tr   [MAXT];
  logic [1:0]        commit_tr [MAXT];
  logic [ERR_W-1:0]  err_tr    [MAXT][2];
  logic [31:0]       exp_q[$];
  int fin_at;
  int fin_cnt;

  task automatic clear_trace();
    for (int t = 0; t < MAXT; t++) begin
      halt_tr[t]   = 2'b00;
      commit_tr[t] = 2'b11;
      err_tr[t][0] = '0;
      err_tr[t][1] = '0;
    end
  endtask

  task automatic do_reset(input int tmo, input int slim);
    bus.halt_i        = '0;
    bus.commit_i      = '0;
    bus.errcode_i     = '0;
    bus.timeout_i     = CNT_W'(tmo);
    bus.stall_limit_i = CNT_W'(slim);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Drives one trace cycle per clock; cycle c's outputs are sampled just after its edge (cycle c+1).
  task automatic drive_trace(input int len);
    fin_at  = -1;
    fin_cnt = 0;
    for (int c = 0; c < len; c++) begin
      bus.halt_i    = halt_tr[c];
      bus.commit_i  = commit_tr[c];
      bus.errcode_i = {err_tr[c][1], err_tr[c][0]};
      @(posedge clk);
      #1;
      if (bus.finish_o === 1'b1) begin
        fin_cnt++;
        if (fin_at < 0) fin_at = c + 1;
      end
    end
    bus.halt_i    = '0;
    bus.commit_i  = '0;
    bus.errcode_i = '0;
  endtask

  // Scans the trace for the first cycle where any termination rule holds.
  task automatic model(input int len, input int tmo, input int slim,
                       output int term, output int cause, output int ch, output int err);
    bit halted[2];
    int last_commit[2];
    term = -1; cause = 0; ch = 0; err = 0;
    halted[0] = 0; halted[1] = 0;
    last_commit[0] = -1; last_commit[1] = -1;
    for (int t = 0; t < len; t++) begin
      for (int k = 0; k < 2; k++) if (halt_tr[t][k]) halted[k] = 1;
      if (err_tr[t][0] != 0)            begin cause = 2; ch = 0; err = int'(err_tr[t][0]); end
      else if (err_tr[t][1] != 0)       begin cause = 2; ch = 1; err = int'(err_tr[t][1]); end
      else if (halted[0] && halted[1])  cause = 1;
      else if (tmo != 0 && t + 1 == tmo) cause = 3;
      else begin
        for (int k = 0; k < 2; k++) begin
          if (cause == 0 && slim != 0 && !halted[k] && !commit_tr[t][k] && (t - last_commit[k]) == slim) begin
            cause = 4; ch = k;
          end
        end
      end
      if (cause != 0) begin
        term = t;
        return;
      end
      for (int k = 0; k < 2; k++) if (commit_tr[t][k]) last_commit[k] = t;
    end
  endtask

  task automatic test_reset();
    bus.halt_i = 2'b11; bus.commit_i = 2'b00; bus.errcode_i = 32'h0001_0002;
    bus.timeout_i = 1; bus.stall_limit_i = 1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus.finish_o !== 1'b0) begin n_fail++; $display("FAIL reset_finish got=%0b want=0", bus.finish_o); end
    n_checks++; if (bus.done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%0b want=0", bus.done_o); end
    n_checks++; if (bus.cause_o !== 3'd0) begin n_fail++; $display("FAIL reset_cause got=%0d want=0", bus.cause_o); end
    n_checks++; if (bus.cause_ch_o !== '0) begin n_fail++; $display("FAIL reset_ch got=%0d want=0", bus.cause_ch_o); end
    n_checks++; if (bus.err_code_o !== '0) begin n_fail++; $display("FAIL reset_err got=%0h want=0", bus.err_code_o); end
    n_checks++; if (bus.cycle_o !== '0) begin n_fail++; $display("FAIL reset_cycle got=%0d want=0", bus.cycle_o); end
  endtask

  task automatic test_halt();
    clear_trace();
    halt_tr[10] = 2'b01;
    halt_tr[20] = 2'b10;
    do_reset(0, 0);
    drive_trace(30);
    n_checks++; if (fin_at != 21) begin n_fail++; $display("FAIL halt_finish_cycle got=%0d want=21", fin_at); end
    n_checks++; if (fin_cnt != 1) begin n_fail++; $display("FAIL halt_finish_pulses got=%0d want=1", fin_cnt); end
    n_checks++; if (bus.cause_o !== 3'd1) begin n_fail++; $display("FAIL halt_cause got=%0d want=1", bus.cause_o); end
    n_checks++; if (bus.done_o !== 1'b1) begin n_fail++; $display("FAIL halt_done_held got=%0b want=1", bus.done_o); end
    n_checks++; if (bus.cycle_o !== 32'd21) begin n_fail++; $display("FAIL halt_cycle got=%0d want=21", bus.cycle_o); end
  endtask

  task automatic test_error_drain();
    clear_trace();
    err_tr[50][1] = 16'h0003;
    halt_tr[51]   = 2'b01;
    halt_tr[52]   = 2'b10;
    err_tr[53][0] = 16'h0044;
    do_reset(0, 0);
    drive_trace(70);
    n_checks++; if (fin_at != 56) begin n_fail++; $display("FAIL err_finish_cycle got=%0d want=56", fin_at); end
    n_checks++; if (fin_cnt != 1) begin n_fail++; $display("FAIL err_finish_pulses got=%0d want=1", fin_cnt); end
    n_checks++; if (bus.cause_o !== 3'd2) begin n_fail++; $display("FAIL err_cause got=%0d want=2", bus.cause_o); end
    n_checks++; if (bus.cause_ch_o !== 2'd1) begin n_fail++; $display("FAIL err_ch got=%0d want=1", bus.cause_ch_o); end
    n_checks++; if (bus.err_code_o !== 16'h0003) begin n_fail++; $display("FAIL err_code got=%0h want=3", bus.err_code_o); end
    n_checks++; if (bus.cycle_o !== 32'd51) begin n_fail++; $display("FAIL err_cycle_frozen got=%0d want=51", bus.cycle_o); end
  endtask

  task automatic test_error_priority();
    clear_trace();
    err_tr[3][0] = 16'h0005;
    err_tr[3][1] = 16'h0007;
    halt_tr[3]   = 2'b11;
    do_reset(4, 0);
    drive_trace(20);
    n_checks++; if (fin_at != 9) begin n_fail++; $display("FAIL prio_finish_cycle got=%0d want=9", fin_at); end
    n_checks++; if (bus.cause_o !== 3'd2) begin n_fail++; $display("FAIL prio_cause got=%0d want=2", bus.cause_o); end
    n_checks++; if (bus.cause_ch_o !== 2'd0) begin n_fail++; $display("FAIL prio_ch got=%0d want=0", bus.cause_ch_o); end
    n_checks++; if (bus.err_code_o !== 16'h0005) begin n_fail++; $display("FAIL prio_err got=%0h want=5", bus.err_code_o); end
  endtask

  task automatic test_timeout();
    clear_trace();
    do_reset(100, 0);
    drive_trace(110);
    n_checks++; if (fin_at != 100) begin n_fail++; $display("FAIL tmo_finish_cycle got=%0d want=100", fin_at); end
    n_checks++; if (bus.cause_o !== 3'd3) begin n_fail++; $display("FAIL tmo_cause got=%0d want=3", bus.cause_o); end
    n_checks++; if (bus.cause_ch_o !== 2'd0) begin n_fail++; $display("FAIL tmo_ch got=%0d want=0", bus.cause_ch_o); end
    n_checks++; if (bus.cycle_o !== 32'd100) begin n_fail++; $display("FAIL tmo_cycle got=%0d want=100", bus.cycle_o); end
  endtask

  task automatic test_stall();
    clear_trace();
    for (int t = 30; t < MAXT; t++) commit_tr[t] = 2'b01;
    do_reset(0, 8);
    drive_trace(50);
    n_checks++; if (fin_at != 38) begin n_fail++; $display("FAIL stall_finish_cycle got=%0d want=38", fin_at); end
    n_checks++; if (bus.cause_o !== 3'd4) begin n_fail++; $display("FAIL stall_cause got=%0d want=4", bus.cause_o); end
    n_checks++; if (bus.cause_ch_o !== 2'd1) begin n_fail++; $display("FAIL stall_ch got=%0d want=1", bus.cause_ch_o); end
    n_checks++; if (bus.cycle_o !== 32'd38) begin n_fail++; $display("FAIL stall_cycle got=%0d want=38", bus.cycle_o); end
  endtask

  task automatic test_reset_mid_drain();
    clear_trace();
    err_tr[5][0] = 16'h0009;
    do_reset(0, 0);
    drive_trace(8);
    n_checks++; if (bus.cycle_o !== 32'd6) begin n_fail++; $display("FAIL drain_cycle_frozen got=%0d want=6", bus.cycle_o); end
    #2;
    rst = 1'b0;
    #1;
    n_checks++; if (bus.cause_o !== 3'd0) begin n_fail++; $display("FAIL async_rst_cause got=%0d want=0", bus.cause_o); end
    n_checks++; if (bus.err_code_o !== '0) begin n_fail++; $display("FAIL async_rst_err got=%0h want=0", bus.err_code_o); end
    n_checks++; if (bus.cycle_o !== '0) begin n_fail++; $display("FAIL async_rst_cycle got=%0d want=0", bus.cycle_o); end
    clear_trace();
    err_tr[2][1] = 16'h0022;
    do_reset(0, 0);
    drive_trace(15);
    n_checks++; if (fin_at != 8) begin n_fail++; $display("FAIL recap_finish_cycle got=%0d want=8", fin_at); end
    n_checks++; if (bus.cause_ch_o !== 2'd1) begin n_fail++; $display("FAIL recap_ch got=%0d want=1", bus.cause_ch_o); end
    n_checks++; if (bus.err_code_o !== 16'h0022) begin n_fail++; $display("FAIL recap_err got=%0h want=22", bus.err_code_o); end
  endtask

  task automatic test_random();
    int len, tmo, slim, pden, term, cause, ch, err, exp_fin;
    logic [31:0] e;
    len = 90;
    for (int it = 0; it < 12; it++) begin
      clear_trace();
      tmo  = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(15, 70));
      slim = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(4, 12));
      case ($urandom_range(0, 2))
        0:       pden = 2;
        1:       pden = 4;
        default: pden = 16;
      endcase
      for (int t = 0; t < len; t++) begin
        for (int k = 0; k < 2; k++) begin
          halt_tr[t][k]   = ($urandom_range(0, 29) == 0);
          commit_tr[t][k] = ($urandom_range(0, pden - 1) != 0);
          if (t < len - 10 && $urandom_range(0, 149) == 0) err_tr[t][k] = ERR_W'($urandom_range(1, 16'hFFFF));
        end
      end
      model(len, tmo, slim, term, cause, ch, err);
      exp_fin = (term < 0) ? -1 : ((cause == 2) ? term + DRAIN + 1 : term + 1);
      exp_q.push_back(32'(exp_fin));
      exp_q.push_back(32'(cause));
      exp_q.push_back(32'(ch));
      exp_q.push_back(32'(err));
      exp_q.push_back((term < 0) ? 32'(len) : 32'(term + 1));
      do_reset(tmo, slim);
      drive_trace(len);
      e = exp_q.pop_front();
      n_checks++; if (32'(fin_at) !== e) begin n_fail++; $display("FAIL rnd%0d_finish_cycle got=%0d want=%0d", it, fin_at, $signed(e)); end
      n_checks++; if (fin_cnt != ((term < 0) ? 0 : 1)) begin n_fail++; $display("FAIL rnd%0d_finish_pulses got=%0d", it, fin_cnt); end
      e = exp_q.pop_front();
      n_checks++; if (32'(bus.cause_o) !== e) begin n_fail++; $display("FAIL rnd%0d_cause got=%0d want=%0d", it, bus.cause_o, e); end
      e = exp_q.pop_front();
      n_checks++; if (32'(bus.cause_ch_o) !== e) begin n_fail++; $display("FAIL rnd%0d_ch got=%0d want=%0d", it, bus.cause_ch_o, e); end
      e = exp_q.pop_front();
      n_checks++; if (32'(bus.err_code_o) !== e) begin n_fail++; $display("FAIL rnd%0d_err got=%0h want=%0h", it, bus.err_code_o, e); end
      e = exp_q.pop_front();
      n_checks++; if (bus.cycle_o !== e) begin n_fail++; $display("FAIL rnd%0d_cycle got=%0d want=%0d", it, bus.cycle_o, e); end
      n_checks++; if (bus.done_o !== (term >= 0)) begin n_fail++; $display("FAIL rnd%0d_done got=%0b want=%0b", it, bus.done_o, term >= 0); end
    end
  endtask

  initial begin
    test_reset();
    test_halt();
    test_error_drain();
    test_error_priority();
    test_timeout();
    test_stall();
    test_reset_mid_drain();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
